// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU datapath types and default widths
package cpu_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_clr_state_t;

endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one registered read port with write-to-read forwarding
module regfile_rdport #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rse,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_fwd_we,
  input  logic [ADDR_W-1:0] i_fwd_addr,
  input  logic [DATA_W-1:0] i_fwd_data,
  input  logic              i_busy,
  output logic [DATA_W-1:0] o_rsdata,
  output logic              o_rsvalid
);

  logic              w_hit;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  // i_fwd_we is already qualified as an accepted write by the top level
  assign w_hit = i_fwd_we && (i_fwd_addr == i_raddr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_rse && !i_busy) begin
      r_data  <= w_hit ? i_fwd_data : i_rdata;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign o_rsdata  = r_data;
  assign o_rsvalid = r_valid;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with sequenced clear
// Optional REGFILE_R0_ZERO_EN: register 0 hardwired to zero.
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD-1:0]        rse,
  input  logic [NUM_RD*ADDR_W-1:0] rsaddr,
  output logic [NUM_RD*DATA_W-1:0] rsdata,
  output logic [NUM_RD-1:0]        rsvalid,
  input  logic                     clr,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  rf_clr_state_t     r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;
  logic              w_idle;
  logic              w_wr_acc;

  assign w_idle = (r_state == IDLE);

`ifdef REGFILE_R0_ZERO_EN
  assign w_wr_acc = we && w_idle && !clr && (waddr != '0);
`else
  assign w_wr_acc = we && w_idle && !clr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else if (w_wr_acc) begin
            r_mem[waddr] <= wdata;
          end
        end
        CLEAR: begin
          r_mem[r_cnt] <= '0;
          r_cnt        <= r_cnt + ADDR_W'(1);
          if (r_cnt == ADDR_W'(DEPTH - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_raddr;
    logic [DATA_W-1:0] w_rdata;

    assign w_raddr = rsaddr[g*ADDR_W +: ADDR_W];
`ifdef REGFILE_R0_ZERO_EN
    assign w_rdata = (w_raddr == '0) ? '0 : r_mem[w_raddr];
`else
    assign w_rdata = r_mem[w_raddr];
`endif

    regfile_rdport #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_rdport (
      .i_clk      (clk),
      .i_rst_n    (rst),
      .i_rse      (rse[g]),
      .i_raddr    (w_raddr),
      .i_rdata    (w_rdata),
      .i_fwd_we   (w_wr_acc),
      .i_fwd_addr (waddr),
      .i_fwd_data (wdata),
      .i_busy     (!w_idle),
      .o_rsdata   (rsdata[g*DATA_W +: DATA_W]),
      .o_rsvalid  (rsvalid[g])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (2 read ports, 16x16)
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic [1:0]  rse;
  logic [7:0]  rsaddr;
  logic [31:0] rsdata;
  logic [1:0]  rsvalid;
  logic        clr;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  regfile_mp #(
    .DATA_W(16),
    .ADDR_W(4),
    .NUM_RD(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .rse     (rse),
    .rsaddr  (rsaddr),
    .rsdata  (rsdata),
    .rsvalid (rsvalid),
    .clr     (clr),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pops per-port expectations whenever the DUT flags a read.
  always @(negedge clk) begin
    if (rst) begin
      if (rsvalid[0]) begin
        n_chk++;
        if (q0.size() == 0) begin
          n_err++;
          $display("FAIL port0_unexpected_valid: got data %h expected no read", rsdata[15:0]);
        end else if (rsdata[15:0] !== q0[0]) begin
          n_err++;
          $display("FAIL port0_data: got %h expected %h", rsdata[15:0], q0[0]);
          void'(q0.pop_front());
        end else begin
          void'(q0.pop_front());
        end
      end
      if (rsvalid[1]) begin
        n_chk++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL port1_unexpected_valid: got data %h expected no read", rsdata[31:16]);
        end else if (rsdata[31:16] !== q1[0]) begin
          n_err++;
          $display("FAIL port1_data: got %h expected %h", rsdata[31:16], q1[0]);
          void'(q1.pop_front());
        end else begin
          void'(q1.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    we  = 1'b0;
    rse = 2'b00;
    clr = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
  endtask

  task automatic rd(input int p, input logic [3:0] a, input logic [15:0] e);
    rse[p] = 1'b1;
    rsaddr[p*4 +: 4] = a;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b0;
    we     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    rse    = '0;
    rsaddr = '0;
    clr    = 1'b0;
    #12;
    chk("reset_rsdata", {16'h0, rsdata[31:16]} | {16'h0, rsdata[15:0]}, 32'h0);
    chk("reset_rsvalid", {30'h0, rsvalid}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b1;

    // write then read from storage
    wr(4'd3, 16'h1234); step();
    rd(0, 4'd3, 16'h1234); step();

    // same-edge forwarding to both ports
    wr(4'd5, 16'hBEEF); rd(0, 4'd5, 16'hBEEF); rd(1, 4'd5, 16'hBEEF); step();
    rd(0, 4'd5, 16'hBEEF); rd(1, 4'd3, 16'h1234); step();

    // independent ports, then drop port 1
    wr(4'd1, 16'h0011); step();
    wr(4'd2, 16'h0022); step();
    rd(0, 4'd1, 16'h0011); rd(1, 4'd2, 16'h0022); step();
    rd(0, 4'd1, 16'h0011); step();
    chk("port1_valid_drop", {31'h0, rsvalid[1]}, 32'h0);
    chk("port1_data_hold", {16'h0, rsdata[31:16]}, 32'h0022);

    // register 0 behaviour
`ifdef REGFILE_R0_ZERO_EN
    wr(4'd0, 16'h5555); rd(0, 4'd0, 16'h0000); step();
    rd(0, 4'd0, 16'h0000); rd(1, 4'd0, 16'h0000); step();
`else
    wr(4'd0, 16'h5555); rd(0, 4'd0, 16'h5555); step();
    rd(0, 4'd0, 16'h5555); rd(1, 4'd0, 16'h5555); step();
`endif

    // full clear sequence
    for (int a = 0; a < 16; a++) begin
      wr(4'(a), 16'hFFFF); step();
    end
    rd(0, 4'd9, 16'hFFFF); rd(1, 4'd9, 16'hFFFF); step();
    clr = 1'b1; step();
    chk("clr_busy_rise", {31'h0, busy}, 32'h1);
    for (int k = 1; k <= 16; k++) begin
      wr(4'd7, 16'hAAAA);
      rse = 2'b11; rsaddr = 8'h77;
      clr = (k == 4);
      step();
      chk($sformatf("clr_busy_k%0d", k), {31'h0, busy}, (k < 16) ? 32'h1 : 32'h0);
      chk($sformatf("clr_rsvalid_k%0d", k), {30'h0, rsvalid}, 32'h0);
      chk($sformatf("clr_hold_k%0d", k), rsdata, 32'hFFFF_FFFF);
    end
    for (int a = 0; a < 16; a++) begin
      rd(0, 4'(a), 16'h0000); rd(1, 4'(15 - a), 16'h0000); step();
    end

    // reset in the middle of a clear
    wr(4'd4, 16'h1357); step();
    rd(0, 4'd4, 16'h1357); rd(1, 4'd4, 16'h1357); step();
    clr = 1'b1; step();
    for (int k = 0; k < 5; k++) step();
    chk("midclr_busy_pre", {31'h0, busy}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("midclr_busy", {31'h0, busy}, 32'h0);
    chk("midclr_rsdata", rsdata, 32'h0);
    chk("midclr_rsvalid", {30'h0, rsvalid}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wr(4'd4, 16'h0042); rd(0, 4'd4, 16'h0042); step();
    rd(1, 4'd4, 16'h0042); rd(0, 4'd5, 16'h0000); step();
    chk("after_rst_busy", {31'h0, busy}, 32'h0);

    step(); step();
    chk("q0_drain", q0.size(), 32'h0);
    chk("q1_drain", q1.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
